// File: rtl/serial_sub_n.sv
// serial_sub_n: digit-serial N-bit subtractor, D = A - B - BIN, LSB digit first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_sub_n: DIGIT must divide WIDTH exactly");
  end

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q;
  state_t           state_n;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;
  logic             brw_q;
  logic             bout_q;
  logic             done_q;

  logic             load;
  logic             step;
  logic             last;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] diff;
  logic             brw_n;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_n = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == LAST_CNT) begin
          last    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // One digit of (DIGIT+1)-bit subtraction with borrow
  always_comb begin
    a_dig = a_q[cnt_q*DIGIT +: DIGIT];
    b_dig = b_q[cnt_q*DIGIT +: DIGIT];
    {brw_n, diff} = {1'b0, a_dig}
                  - {1'b0, b_dig}
                  - {{DIGIT{1'b0}}, brw_q};
  end

  // Operand latch, digit write-back, borrow chain and completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
      brw_q  <= 1'b0;
      bout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= last;
      if (load) begin
        a_q   <= a;
        b_q   <= b;
        brw_q <= bin;
        cnt_q <= '0;
        d_q   <= '0;
      end else if (step) begin
        d_q[cnt_q*DIGIT +: DIGIT] <= diff;
        brw_q <= brw_n;
        cnt_q <= cnt_q + CW'(1);
        if (last) begin
          bout_q <= brw_n;
        end
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;

  // Signed overflow from latched operand signs and final result sign
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (last) begin
      ovf_q <= (a_q[WIDTH-1] ^ b_q[WIDTH-1])
             & (diff[DIGIT-1] ^ a_q[WIDTH-1]);
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;

endmodule
